// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
//   Shared types and constants for the sprite compositor.
//   sprite_desc_t : packed 24-bit descriptor {en, img[2:0], x[9:0], y[9:0]},
//                   bit-compatible with the wr_desc write port.
//   HRES/VRES     : visible raster size; COORD_W : hcount/vcount width;
//   RGB_W         : pixel colour width; IMG_W : image-select width.
// -----------------------------------------------------------------------------
package sprite_pkg;
   localparam int HRES    = 640;
   localparam int VRES    = 480;
   localparam int COORD_W = 10;
   localparam int RGB_W   = 24;
   localparam int IMG_W   = 3;

   typedef struct packed {
      logic               en;
      logic [IMG_W-1:0]   img;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } sprite_desc_t;
endpackage

// File: rtl/sprite_hit_unit.sv
// -----------------------------------------------------------------------------
// sprite_hit_unit
//   Combinational in-box test for one sprite slot.
//   Ports:
//     en, x, y       : enable and top-left corner of the sprite
//     hcount, vcount : current pixel
//     hit            : pixel lies inside the SPR_DIM x SPR_DIM box
//     col, row       : texel offsets within the sprite
// -----------------------------------------------------------------------------
module sprite_hit_unit
   import sprite_pkg::*;
#(
   parameter  int SPR_DIM = 32,
   localparam int OFF_W   = $clog2(SPR_DIM)
) (
   input  logic               en,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] hcount,
   input  logic [COORD_W-1:0] vcount,
   output logic               hit,
   output logic [OFF_W-1:0]   col,
   output logic [OFF_W-1:0]   row
);
   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;

   // Unsigned 10-bit differences: a sprite to the right of / below the pixel
   // wraps to a large value and misses. SPR_DIM is a power of two, so
   // "offset < SPR_DIM" is simply "upper offset bits are zero".
   assign dx  = hcount - x;
   assign dy  = vcount - y;
   assign hit = en && (dx[COORD_W-1:OFF_W] == '0) && (dy[COORD_W-1:OFF_W] == '0);
   assign col = dx[OFF_W-1:0];
   assign row = dy[OFF_W-1:0];
endmodule

// File: rtl/sprite_layer_engine.sv
// -----------------------------------------------------------------------------
// sprite_layer_engine
//   Multi-sprite compositor: shadow descriptors committed atomically on
//   frame_start, lowest-slot-wins hit priority, one shared sprite-ROM port,
//   3-cycle pixel pipeline, one pixel per clock.
//   Ports:
//     clk, reset            : pixel clock, synchronous active-high reset
//     wr_en/wr_slot/wr_desc : shadow descriptor write (out-of-range slots ignored)
//     hcount, vcount        : current pixel
//     frame_start           : commit pulse (shadow -> active)
//     bg_rgb                : background colour
//     rom_img, rom_addr     : sprite-ROM request ({row,col})
//     rom_q                 : ROM data, one cycle after the request
//     pix_rgb               : composited pixel, 3 cycles after hcount/vcount
//     commit_cnt            : committed-frame counter (wraps)
//     collide               : sticky per-slot collision flags
//   Build option: define COLLISION_DETECT_EN to enable collision detection;
//   otherwise collide is tied to zero.
// -----------------------------------------------------------------------------
module sprite_layer_engine
   import sprite_pkg::*;
#(
   parameter  int               NUM_SPRITES = 20,
   parameter  int               SPR_DIM     = 32,
   parameter  int               NUM_IMAGES  = 8,
   parameter  logic [RGB_W-1:0] TRANSP_KEY  = 24'h000000,
   localparam int               SLOT_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
   localparam int               OFF_W       = $clog2(SPR_DIM)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [SLOT_W-1:0]      wr_slot,
   input  logic [RGB_W-1:0]       wr_desc,
   input  logic [COORD_W-1:0]     hcount,
   input  logic [COORD_W-1:0]     vcount,
   input  logic                   frame_start,
   input  logic [RGB_W-1:0]       bg_rgb,
   output logic [IMG_W-1:0]       rom_img,
   output logic [2*OFF_W-1:0]     rom_addr,
   input  logic [RGB_W-1:0]       rom_q,
   output logic [RGB_W-1:0]       pix_rgb,
   output logic [7:0]             commit_cnt,
   output logic [NUM_SPRITES-1:0] collide
);
   localparam logic [IMG_W-1:0] IMG_MASK = IMG_W'(NUM_IMAGES - 1);

   sprite_desc_t           shadow [NUM_SPRITES];
   sprite_desc_t           active [NUM_SPRITES];
   sprite_desc_t           wr_d;
   logic [NUM_SPRITES-1:0] wr_sel;

   assign wr_d = wr_desc;

   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_SPRITES; i++)
         wr_sel[i] = wr_en && (int'(wr_slot) == i);
   end

   // A write coinciding with the commit is forwarded straight into active.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         commit_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr_sel[i])
               shadow[i] <= wr_d;
            if (frame_start)
               active[i] <= wr_sel[i] ? wr_d : shadow[i];
         end
         if (frame_start)
            commit_cnt <= commit_cnt + 8'd1;
      end
   end

   logic [NUM_SPRITES-1:0] hits;
   logic [OFF_W-1:0]       col_off [NUM_SPRITES];
   logic [OFF_W-1:0]       row_off [NUM_SPRITES];

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
      sprite_hit_unit #(.SPR_DIM(SPR_DIM)) u_hit (
         .en     (active[g].en),
         .x      (active[g].x),
         .y      (active[g].y),
         .hcount (hcount),
         .vcount (vcount),
         .hit    (hits[g]),
         .col    (col_off[g]),
         .row    (row_off[g])
      );
   end

   logic             win_hit;
   logic [IMG_W-1:0] win_img;
   logic [OFF_W-1:0] win_col;
   logic [OFF_W-1:0] win_row;

   // Scan from the top slot down so the lowest hitting index is written last.
   always_comb begin
      win_hit = |hits;
      win_img = '0;
      win_col = '0;
      win_row = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hits[i]) begin
            win_img = active[i].img;
            win_col = col_off[i];
            win_row = row_off[i];
         end
      end
   end

   // ---- S1 -> S2 : winner registered straight onto the ROM request ----
   logic             vld_p1;
   logic             miss_p1;
   logic [RGB_W-1:0] bg_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         miss_p1  <= 1'b1;
         rom_img  <= '0;
         rom_addr <= '0;
      end else begin
         vld_p1  <= 1'b1;
         miss_p1 <= !win_hit;
         // On a miss the request holds so the ROM address bus stays quiet.
         if (win_hit) begin
            rom_img  <= win_img & IMG_MASK;
            rom_addr <= {win_row, win_col};
         end
      end
   end

   always_ff @(posedge clk)
      bg_p1 <= bg_rgb;

   // ---- S2 -> S3 : ROM access in flight, carry miss and background ----
   logic             vld_p2;
   logic             miss_p2;
   logic [RGB_W-1:0] bg_p2;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p2  <= 1'b0;
         miss_p2 <= 1'b1;
      end else begin
         vld_p2  <= vld_p1;
         miss_p2 <= miss_p1;
      end
   end

   always_ff @(posedge clk)
      bg_p2 <= bg_p1;

   // ---- S3 : final colour select ----
   // A transparent texel shows background, not the next sprite down.
   always_ff @(posedge clk) begin
      if (reset)
         pix_rgb <= '0;
      else if (vld_p2)
         pix_rgb <= (miss_p2 || (rom_q == TRANSP_KEY)) ? bg_p2 : rom_q;
   end

`ifdef COLLISION_DETECT_EN
   logic multi_hit;

   // Two or more bits set <=> clearing the lowest set bit leaves something.
   assign multi_hit = |(hits & (hits - NUM_SPRITES'(1)));

   always_ff @(posedge clk) begin
      if (reset)
         collide <= '0;
      else if (frame_start)
         collide <= multi_hit ? hits : '0;
      else if (multi_hit)
         collide <= collide | hits;
   end
`else
   assign collide = '0;
`endif
endmodule

// File: tb/tb_sprite_layer_engine.sv
module tb_sprite_layer_engine;
   localparam int NS = 20;
   localparam logic [23:0] TKEY = 24'h000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_slot;
   logic [23:0] wr_desc;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        frame_start;
   logic [23:0] bg_rgb;
   logic [2:0]  rom_img;
   logic [9:0]  rom_addr;
   logic [23:0] rom_q = '0;
   logic [23:0] pix_rgb;
   logic [7:0]  commit_cnt;
   logic [NS-1:0] collide;

   sprite_layer_engine dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_slot(wr_slot), .wr_desc(wr_desc),
      .hcount(hcount), .vcount(vcount), .frame_start(frame_start), .bg_rgb(bg_rgb),
      .rom_img(rom_img), .rom_addr(rom_addr), .rom_q(rom_q), .pix_rgb(pix_rgb),
      .commit_cnt(commit_cnt), .collide(collide)
   );

   always #5 clk = ~clk;

   // Sprite ROM contents: every texel whose low address bits are 5 is transparent.
   function automatic logic [23:0] rom_fn(logic [2:0] img, logic [9:0] addr);
      if (addr[2:0] == 3'd5) return TKEY;
      return {4'hA, 1'b0, img, 6'h00, addr};
   endfunction

   always @(posedge clk) rom_q <= rom_fn(rom_img, rom_addr);

   // ---------------- reference model ----------------
   logic [23:0] m_shadow [NS];
   logic [23:0] m_active [NS];
   int          mct;

   function automatic logic [23:0] mk_desc(int en, int img, int x, int y);
      return {1'(en), 3'(img), 10'(x), 10'(y)};
   endfunction

   function automatic logic [23:0] ref_pix(logic [9:0] h, logic [9:0] v, logic [23:0] bg);
      for (int s = 0; s < NS; s++) begin
         logic [23:0] d;
         int dx, dy;
         logic [23:0] t;
         d  = m_active[s];
         dx = (int'(h) - int'(d[19:10]) + 1024) % 1024;
         dy = (int'(v) - int'(d[9:0]) + 1024) % 1024;
         if (d[23] && dx < 32 && dy < 32) begin
            t = rom_fn(d[22:20], 10'(dy * 32 + dx));
            return (t == TKEY) ? bg : t;
         end
      end
      return bg;
   endfunction

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(int cycles);
      reset = 1'b1;
      repeat (cycles) step();
      reset = 1'b0;
      for (int s = 0; s < NS; s++) begin m_shadow[s] = '0; m_active[s] = '0; end
      mct = 0;
   endtask

   task automatic write_desc(int slot, logic [23:0] d);
      wr_en = 1'b1; wr_slot = 5'(slot); wr_desc = d;
      step();
      wr_en = 1'b0;
      if (slot < NS) m_shadow[slot] = d;
   endtask

   task automatic commit();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int s = 0; s < NS; s++) m_active[s] = m_shadow[s];
      mct++;
   endtask

   task automatic commit_with_write(int slot, logic [23:0] d);
      wr_en = 1'b1; wr_slot = 5'(slot); wr_desc = d; frame_start = 1'b1;
      step();
      wr_en = 1'b0; frame_start = 1'b0;
      if (slot < NS) m_shadow[slot] = d;
      for (int s = 0; s < NS; s++) m_active[s] = m_shadow[s];
      mct++;
   endtask

   task automatic apply_pixel(int h, int v, logic [23:0] bg,
                              output logic [2:0] r_img, output logic [9:0] r_addr,
                              output logic [23:0] r_pix);
      hcount = 10'(h); vcount = 10'(v); bg_rgb = bg;
      step();
      r_img = rom_img; r_addr = rom_addr;
      step();
      step();
      r_pix = pix_rgb;
   endtask

   // One new pixel per clock, compared against the model 3 cycles later.
   task automatic run_stream(int n, bit near);
      logic [23:0] expq[$];
      int h, v, s;
      for (int c = 0; c < n + 2; c++) begin
         if (c < n) begin
            if (near) begin
               s = $urandom_range(0, NS - 1);
               h = (int'(m_active[s][19:10]) + $urandom_range(0, 40) - 4 + 1024) % 1024;
               v = (int'(m_active[s][9:0]) + $urandom_range(0, 40) - 4 + 1024) % 1024;
            end else begin
               h = $urandom_range(0, 799);
               v = $urandom_range(0, 524);
            end
            hcount = 10'(h); vcount = 10'(v); bg_rgb = 24'($urandom);
            expq.push_back(ref_pix(hcount, vcount, bg_rgb));
         end
         step();
         if (c >= 2) check("stream_pix", pix_rgb, expq.pop_front());
      end
   endtask

   typedef struct {
      int          phase;
      int          h;
      int          v;
      logic [23:0] bg;
      logic [23:0] exp;
      string       name;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(int ph, int h, int v, logic [23:0] bg, logic [23:0] exp, string nm);
      vec_t e;
      e.phase = ph; e.h = h; e.v = v; e.bg = bg; e.exp = exp; e.name = nm;
      tbl.push_back(e);
   endfunction

   task automatic run_table(int ph);
      logic [2:0] ri; logic [9:0] ra; logic [23:0] rp;
      foreach (tbl[k]) begin
         if (tbl[k].phase == ph) begin
            apply_pixel(tbl[k].h, tbl[k].v, tbl[k].bg, ri, ra, rp);
            check(tbl[k].name, rp, tbl[k].exp);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] ri; logic [9:0] ra; logic [23:0] rp;

      // single-sprite path
      add(2, 100,  50, 24'h102030, rom_fn(3'd2, 10'd0),    "s2_origin");
      add(2, 131,  81, 24'h102030, rom_fn(3'd2, 10'd1023), "s2_last_texel");
      add(2, 132,  50, 24'h112233, 24'h112233,              "s2_right_edge_bg");
      add(2,  99,  50, 24'h445566, 24'h445566,              "s2_left_wrap_bg");
      add(2, 100,  82, 24'h778899, 24'h778899,              "s2_below_bg");
      add(2, 105,  53, 24'h0000FF, 24'h0000FF,              "s2_transparent_bg");
      // priority between overlapping slots 0 and 5
      add(3, 200, 200, 24'h102030, rom_fn(3'd2, 10'd330),  "s3_slot0_wins");
      add(3, 203, 200, 24'hABCDEF, 24'hABCDEF,              "s3_transp_no_fallthrough");
      add(3, 225, 225, 24'h102030, rom_fn(3'd4, 10'd825),  "s3_slot5_only");
      add(3, 190, 190, 24'h102030, rom_fn(3'd2, 10'd0),    "s3_slot0_origin");
      // shadow written, not yet committed
      add(4, 200, 200, 24'h102030, rom_fn(3'd2, 10'd330),  "s4_old_still_shown");
      add(4, 400, 300, 24'h0F0F0F, 24'h0F0F0F,              "s4_new_not_shown");
      // after commit
      add(5, 400, 300, 24'h102030, rom_fn(3'd1, 10'd0),    "s5_new_shown");
      add(5, 431, 331, 24'h102030, rom_fn(3'd1, 10'd1023), "s5_new_last");
      add(5, 200, 200, 24'h102030, rom_fn(3'd4, 10'd0),    "s5_slot5_revealed");
      // write-through commit on slot 3, ignored out-of-range write
      add(6,  10,  10, 24'h102030, rom_fn(3'd6, 10'd0),    "s6_writethrough");
      add(6,  41,  20, 24'h102030, rom_fn(3'd6, 10'd351),  "s6_writethrough_texel");
      add(6, 500, 400, 24'h202020, 24'h202020,              "s6_oob_slot_ignored");

      reset = 1'b1; wr_en = 1'b0; wr_slot = '0; wr_desc = '0; frame_start = 1'b0;
      hcount = '0; vcount = '0; bg_rgb = 24'h102030;

      // reset state
      do_reset(3);
      reset = 1'b1;
      step();
      check("rst_pix", pix_rgb, 0);
      check("rst_rom_img", rom_img, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_commit_cnt", commit_cnt, 0);
      check("rst_collide", collide, 0);
      reset = 1'b0;

      // no sprites: background everywhere
      run_stream(40, 1'b0);

      // one sprite, ROM request timing and hold-on-miss
      write_desc(0, mk_desc(1, 2, 100, 50));
      commit();
      check("commit_cnt_1", commit_cnt, 8'(mct));
      apply_pixel(100, 50, 24'h102030, ri, ra, rp);
      check("rom_img_hit", ri, 2);
      check("rom_addr_origin", ra, 0);
      check("pix_origin", rp, rom_fn(3'd2, 10'd0));
      apply_pixel(131, 81, 24'h102030, ri, ra, rp);
      check("rom_addr_last", ra, 10'h3FF);
      apply_pixel(132, 50, 24'h102030, ri, ra, rp);
      check("rom_addr_hold_miss", ra, 10'h3FF);
      check("pix_miss_bg", rp, 24'h102030);
      run_table(2);

      // overlap / priority
      write_desc(5, mk_desc(1, 4, 200, 200));
      write_desc(0, mk_desc(1, 2, 190, 190));
      commit();
      run_table(3);

      // shadow isolation then commit
      write_desc(0, mk_desc(1, 1, 400, 300));
      run_table(4);
      check("commit_cnt_before", commit_cnt, 8'(mct));
      commit();
      check("commit_cnt_after", commit_cnt, 8'(mct));
      run_table(5);

      write_desc(25, mk_desc(1, 0, 500, 400));
      commit_with_write(3, mk_desc(1, 6, 10, 10));
      run_table(6);

      // collision flags on overlapping slots 1 and 2
      write_desc(1, mk_desc(1, 3, 600, 100));
      write_desc(2, mk_desc(1, 5, 610, 110));
      hcount = 10'd0; vcount = 10'd0;
      commit();
      hcount = 10'd615; vcount = 10'd115; bg_rgb = 24'h102030;
      step();
`ifdef COLLISION_DETECT_EN
      check("collide_set", collide, 20'h00006);
      hcount = 10'd0; vcount = 10'd0;
      step();
      check("collide_sticky", collide, 20'h00006);
      commit();
      check("collide_cleared", collide, 20'h00000);
      hcount = 10'd615; vcount = 10'd115;
      commit();
      check("collide_set_wins", collide, 20'h00006);
      hcount = 10'd0; vcount = 10'd0;
      commit();
      check("collide_cleared2", collide, 20'h00000);
`else
      check("collide_tied_off", collide, 20'h00000);
      step();
      check("collide_tied_off2", collide, 20'h00000);
`endif
      apply_pixel(615, 115, 24'h102030, ri, ra, rp);
      check("overlap_slot1_pix", rp, rom_fn(3'd3, 10'd495));

      // randomized descriptors and pixels against the model
      for (int it = 0; it < 4; it++) begin
         for (int k = 0; k < 24; k++)
            write_desc($urandom_range(0, 31),
                       mk_desc($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                               $urandom_range(80, 200), $urandom_range(80, 200)));
         commit();
         run_stream(200, 1'b1);
         run_stream(30, 1'b0);
      end

      // commit counter wrap
      for (int k = 0; k < 256; k++) begin
         commit();
         if ((mct % 256) == 0) check("commit_cnt_wrap0", commit_cnt, 0);
      end
      check("commit_cnt_wrap_end", commit_cnt, 8'(mct % 256));

      // reset discards pending shadow data
      write_desc(7, mk_desc(1, 0, 300, 300));
      do_reset(2);
      commit();
      check("post_reset_cnt", commit_cnt, 1);
      apply_pixel(300, 300, 24'h313131, ri, ra, rp);
      check("post_reset_shadow_gone", rp, 24'h313131);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
